fetch_pc_gen: RTL and testbench

Fetch-stage next-PC generator with a direct-mapped branch target buffer (BTB). Holds the fetch PC, drives it to instruction memory and to the local-history direction predictor, combines the predictor's `pred_taken` with a BTB hit to choose the next PC, and applies execute-stage redirects. BTB entries are written from resolved-branch information, the same stream that trains the direction predictor.

---
 rtl/fetch_pc_gen_if.sv | 43 ++++
 rtl/fetch_pc_gen.sv | 144 ++++++++++++++
 tb/tb_fetch_pc_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen_if
// Purpose : bundles every fetch-stage signal of fetch_pc_gen (fetch request,
//           prediction, execute-stage redirect and resolved-branch update).
// Modports:
//   master - the PC generator: drives pc, pc_valid, fetch_pred_taken and
//            fetch_pred_target; receives pc_ready, pred_taken, redirect_* and br_*.
//   slave  - the surrounding pipeline (imem, predictor, execute stage).
// Signals :
//   pc[31:0]                 current fetch PC
//   pc_valid / pc_ready      fetch request handshake
//   pred_taken               direction prediction for pc (same cycle)
//   fetch_pred_taken         final taken prediction for pc
//   fetch_pred_target[31:0]  predicted next PC
//   redirect_valid / redirect_pc[31:0]        execute-stage redirect
//   br_valid / br_pc / br_taken / br_target   resolved-branch update
// ---------------------------------------------------------------------------
interface fetch_pc_gen_if;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        pred_taken;
  logic        fetch_pred_taken;
  logic [31:0] fetch_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        br_taken;
  logic [31:0] br_target;

  modport master (
    output pc, pc_valid, fetch_pred_taken, fetch_pred_target,
    input  pc_ready, pred_taken, redirect_valid, redirect_pc,
           br_valid, br_pc, br_taken, br_target
  );

  modport slave (
    input  pc, pc_valid, fetch_pred_taken, fetch_pred_target,
    output pc_ready, pred_taken, redirect_valid, redirect_pc,
           br_valid, br_pc, br_taken, br_target
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
// Purpose : fetch-stage next-PC generator. Holds the fetch PC, predicts the
//           next PC from a direct-mapped BTB combined with the external
//           direction prediction, and applies execute-stage redirects.
// Ports   :
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus    - fetch_pc_gen_if.master (pc/pc_valid/pc_ready handshake,
//            pred_taken in, fetch_pred_* out, redirect_* and br_* in)
// Params  :
//   WIDTH_BTB - log2 of BTB entries; index = pc[WIDTH_BTB+1:2],
//               tag = pc[31:WIDTH_BTB+2]
//   RESET_PC  - fetch PC loaded by reset
// Config  :
//   FETCHPC_BTB_EN defined     -> BTB plus index-by-index clear state
//   FETCHPC_BTB_EN not defined -> no BTB, one-cycle clear state, always
//                                 predicts pc+4, pred_taken and br_* ignored
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
  parameter int          WIDTH_BTB = 6,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_gen_if.master bus
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_plus4;
  logic        in_run;
  logic        clear_done;
  logic        pred_taken_int;
  logic [31:0] pred_target_int;

  assign in_run   = (state_reg == S_RUN);
  assign pc_plus4 = pc_reg + 32'd4;

`ifdef FETCHPC_BTB_EN
  localparam int ENTRIES = 1 << WIDTH_BTB;
  localparam int TAG_W   = 32 - WIDTH_BTB - 2;

  logic [WIDTH_BTB-1:0] clr_idx_reg, clr_idx_next;
  logic [ENTRIES-1:0]   valid_reg;
  logic [TAG_W-1:0]     tag_mem    [ENTRIES];
  logic [31:0]          target_mem [ENTRIES];
  logic [WIDTH_BTB-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]     rd_tag, wr_tag;
  logic                 wr_en;
  logic                 hit;
  logic [1:0]           unused_br_pc_low;

  assign rd_idx           = pc_reg[WIDTH_BTB+1:2];
  assign rd_tag           = pc_reg[31:WIDTH_BTB+2];
  assign wr_idx           = bus.br_pc[WIDTH_BTB+1:2];
  assign wr_tag           = bus.br_pc[31:WIDTH_BTB+2];
  assign unused_br_pc_low = bus.br_pc[1:0];

  // Only taken branches allocate; updates arriving while clearing are dropped.
  assign wr_en = in_run && !reset && bus.br_valid && bus.br_taken;

  // Lookup reads the pre-write contents; a same-cycle write shows up next cycle.
  assign hit = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);

  // Gated by in_run so valid bits not yet cleared can never produce a prediction.
  assign pred_taken_int  = in_run && hit && bus.pred_taken;
  assign pred_target_int = pred_taken_int ? target_mem[rd_idx] : pc_plus4;

  assign clear_done   = (clr_idx_reg == {WIDTH_BTB{1'b1}});
  assign clr_idx_next = (state_reg == S_CLEAR) ? clr_idx_reg + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx_reg <= '0;
    end else begin
      clr_idx_reg <= clr_idx_next;
    end
  end

  // One valid flop per entry: cleared when the sweep reaches it, set on allocate.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (!reset && (state_reg == S_CLEAR) && (clr_idx_reg == WIDTH_BTB'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_idx == WIDTH_BTB'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= bus.br_target;
    end
  end
`else
  localparam int unused_width_btb = WIDTH_BTB;

  logic unused_inputs;

  assign unused_inputs   = ^{bus.pred_taken, bus.br_valid, bus.br_pc,
                             bus.br_taken, bus.br_target};
  assign clear_done      = 1'b1;
  assign pred_taken_int  = 1'b0;
  assign pred_target_int = pc_plus4;
`endif

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_CLEAR;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Redirects load pc in either state and never disturb the clear sweep.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if ((state_reg == S_CLEAR) && clear_done) begin
      state_next = S_RUN;
    end
    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc;
    end else if (in_run && bus.pc_ready) begin
      pc_next = pred_target_int;
    end
  end

  assign bus.pc                = pc_reg;
  assign bus.pc_valid          = in_run;
  assign bus.fetch_pred_taken  = pred_taken_int;
  assign bus.fetch_pred_target = pred_target_int;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
// Purpose : self-checking bench for fetch_pc_gen (WIDTH_BTB=6, RESET_PC=0x100)
//           in either build (FETCHPC_BTB_EN defined or not). A behavioural
//           model (fetch PC, clear countdown, BTB as associative arrays)
//           predicts every output each cycle; directed steps cover the
//           scenarios of interest, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;
  localparam int          W   = 6;
  localparam logic [31:0] RPC = 32'h100;
`ifdef FETCHPC_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif
  localparam int CLEAR_LEN = BTB_EN ? (1 << W) : 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  fetch_pc_gen_if bus ();

  fetch_pc_gen #(.WIDTH_BTB(W), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc;
  int          m_clear_left;
  int unsigned btb_tag [int];
  logic [31:0] btb_tgt [int];

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 2) % (1 << W);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a >> (W + 2);
  endfunction

  function automatic logic m_taken();
    int unsigned i = idx_of(m_pc);
    if (!BTB_EN || m_clear_left != 0 || !bus.pred_taken) return 1'b0;
    return btb_tgt.exists(i) && (btb_tag[i] == tag_of(m_pc));
  endfunction

  function automatic logic [31:0] m_target();
    if (m_taken()) return btb_tgt[idx_of(m_pc)];
    return m_pc + 32'd4;
  endfunction

  // Applied right after each rising edge, using the inputs that were present.
  task automatic model_edge();
    logic        run;
    logic [31:0] nxt;
    if (reset) begin
      m_pc         = RPC;
      m_clear_left = CLEAR_LEN;
      btb_tag.delete();
      btb_tgt.delete();
      return;
    end
    run = (m_clear_left == 0);
    nxt = m_target();
    if (BTB_EN && run && bus.br_valid && bus.br_taken) begin
      btb_tag[idx_of(bus.br_pc)] = tag_of(bus.br_pc);
      btb_tgt[idx_of(bus.br_pc)] = bus.br_target;
    end
    if (bus.redirect_valid) m_pc = bus.redirect_pc;
    else if (run && bus.pc_ready) m_pc = nxt;
    if (!run) m_clear_left--;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("pc", bus.pc, m_pc);
    check("pc_valid", 32'(bus.pc_valid), 32'(m_clear_left == 0));
    check("fetch_pred_taken", 32'(bus.fetch_pred_taken), 32'(m_taken()));
    check("fetch_pred_target", bus.fetch_pred_target, m_target());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  // Inputs are set by the caller at the falling edge before calling this.
  task automatic cycle();
    #1;
    $display("cyc %0d rst=%b pc=%h valid=%b rdy=%b ptk=%b fpt=%b tgt=%h redir=%b br=%b",
             cyc, reset, bus.pc, bus.pc_valid, bus.pc_ready, bus.pred_taken,
             bus.fetch_pred_taken, bus.fetch_pred_target, bus.redirect_valid, bus.br_valid);
    check_outputs();
    tick();
  endtask

  task automatic idle_inputs();
    bus.pc_ready       = 1'b0;
    bus.pred_taken     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.br_valid       = 1'b0;
    bus.br_pc          = 32'h0;
    bus.br_taken       = 1'b0;
    bus.br_target      = 32'h0;
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h100 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 2)) << (W + 2));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    cycle();

    // Clear sweep, then sequential fetch.
    reset = 1'b0;
    bus.pc_ready = 1'b1;
    for (int k = 0; k < CLEAR_LEN; k++) cycle();
    check("pc_after_clear", bus.pc, 32'h100);
    check("valid_after_clear", 32'(bus.pc_valid), 32'd1);

    // Allocate 0x108 -> 0x200 while fetching 0x100.
    bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_pc = 32'h108; bus.br_target = 32'h200;
    cycle();
    bus.br_valid = 1'b0;
    cycle();                                  // pc 0x104
    bus.pred_taken = 1'b1;
    cycle();                                  // pc 0x108, hit when BTB present
    bus.pred_taken = 1'b0;
    cycle();                                  // pc 0x200 or 0x10C

    // Same entry, predictor says not taken.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h108;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    check("not_taken_next", bus.pc, 32'h10C);

    // Tag mismatch at 0x208.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h208;
    cycle();
    bus.redirect_valid = 1'b0; bus.pred_taken = 1'b1;
    cycle();
    check("tag_miss_next", bus.pc, 32'h20C);

    // Redirect beats handshake at a hit PC, then stall for 3 cycles.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h108;
    cycle();
    bus.redirect_pc = 32'h400;
    cycle();
    bus.redirect_valid = 1'b0;
    check("redirect_wins", bus.pc, 32'h400);
    bus.pc_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_hold", bus.pc, 32'h400);
    end

    // Same-cycle write and lookup on 0x108: old target used, new one next cycle.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h108;
    cycle();
    bus.redirect_valid = 1'b0;
    bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_pc = 32'h108; bus.br_target = 32'h300;
    cycle();
    bus.br_valid = 1'b0;
    cycle();
    bus.pc_ready = 1'b1;
    cycle();

    // Randomized phase.
    for (int k = 0; k < 300; k++) begin
      bus.pc_ready       = ($urandom_range(0, 3) != 0);
      bus.pred_taken     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 7) == 0);
      bus.redirect_pc    = rand_pc();
      bus.br_valid       = ($urandom_range(0, 2) == 0);
      bus.br_taken       = ($urandom_range(0, 3) != 0);
      bus.br_pc          = rand_pc();
      bus.br_target      = rand_pc();
      cycle();
    end
    idle_inputs();

    // Reset mid-run; redirect and a dropped update during the clear sweep.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < CLEAR_LEN + 12; k++) begin
      bus.br_valid       = (k == 5);
      bus.br_taken       = 1'b1;
      bus.br_pc          = 32'h80;
      bus.br_target      = 32'h500;
      bus.redirect_valid = (k == 10);
      bus.redirect_pc    = 32'h80;
      cycle();
    end
    idle_inputs();
    check("clear_redirect_pc", bus.pc, 32'h80);
    check("clear_redirect_valid", 32'(bus.pc_valid), 32'd1);
    bus.pred_taken = 1'b1;
    bus.pc_ready   = 1'b1;
    #1;
    check("dropped_update_miss", 32'(bus.fetch_pred_taken), 32'd0);
    cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h108;
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    check("old_entry_miss", 32'(bus.fetch_pred_taken), 32'd0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
